// File: rtl/c1541_sd_arbiter_pkg.sv
// Shared types for the C1541 SD channel arbiter.
package c1541_pkg;

   localparam int unsigned MAX_DRIVES = 4;
   localparam int unsigned GRANT_W    = $clog2(MAX_DRIVES);

   typedef logic [GRANT_W-1:0] drive_idx_t;

   typedef enum logic [1:0] {IDLE, ISSUE, XFER} arb_state_t;
   typedef enum logic {OP_RD, OP_WR} sd_op_t;

   // Round-robin successor of cur among num requesters (wraps to 0).
   function automatic drive_idx_t rr_next(input drive_idx_t cur, input int unsigned num);
      if (32'(cur) + 32'd1 >= num) begin
         return '0;
      end
      return cur + 1'b1;
   endfunction

endpackage

// File: rtl/c1541_sd_arbiter_if.sv
// Bundle of requester-side and HPS-side SD channel signals.
// master: the arbiter (owns the HPS channel); slave: requesters plus HPS.
interface c1541_sd_arbiter_if #(
   parameter int unsigned NUM_DRIVES = 2
) ();

   logic [32*NUM_DRIVES-1:0] req_lba;
   logic [NUM_DRIVES-1:0]    req_rd;
   logic [NUM_DRIVES-1:0]    req_wr;
   logic [NUM_DRIVES-1:0]    req_ack;
   logic [8*NUM_DRIVES-1:0]  req_buff_din;
   logic [NUM_DRIVES-1:0]    req_buff_wr;
   logic [31:0]              sd_lba;
   logic                     sd_rd;
   logic                     sd_wr;
   logic                     sd_ack;
   logic                     sd_buff_wr;
   logic [7:0]               sd_buff_din;
   c1541_pkg::drive_idx_t    grant;
   logic                     busy;
   logic                     timeout_err;

   modport master (
      input  req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
      output req_ack, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din, grant, busy, timeout_err
   );

   modport slave (
      output req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
      input  req_ack, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din, grant, busy, timeout_err
   );

endinterface

// File: rtl/c1541_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after rr_ptr_i.
module c1541_rr_pick
   import c1541_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] pending_i,
   input  drive_idx_t         rr_ptr_i,
   output logic               found_o,
   output drive_idx_t         index_o
);

   int unsigned          idx;
   logic [NUM_REQ-1:0]   pend_sh;

   // Scan rr_ptr_i, rr_ptr_i+1, ... modulo NUM_REQ; first hit wins.
   always_comb begin
      found_o = 1'b0;
      index_o = '0;
      idx     = 0;
      pend_sh = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx     = (32'(rr_ptr_i) + k) % NUM_REQ;
         pend_sh = pending_i >> idx;
         if (!found_o && pend_sh[0]) begin
            found_o = 1'b1;
            index_o = drive_idx_t'(idx);
         end
      end
   end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter sharing one HPS SD block channel among NUM_DRIVES track buffers.
// Grant is held for a whole LBA transfer: request, sd_ack rise, sd_ack fall.
// Optional ISSUE timeout: define C1541_SDARB_TIMEOUT_EN.
module c1541_sd_arbiter
   import c1541_pkg::*;
#(
   parameter int unsigned NUM_DRIVES = 2,
   parameter logic [23:0] TIMEOUT    = 24'd8000000
) (
   input logic                clk,
   input logic                reset,
   c1541_sd_arbiter_if.master bus
);

   arb_state_t               state_q, state_d;
   drive_idx_t               rr_ptr_q, rr_ptr_d;
   drive_idx_t               grant_q, grant_d;
   logic [31:0]              lba_q, lba_d;
   sd_op_t                   op_q, op_d;

   logic [NUM_DRIVES-1:0]    pending;
   logic [NUM_DRIVES-1:0]    wr_sh;
   logic [32*NUM_DRIVES-1:0] lba_sh;
   logic [8*NUM_DRIVES-1:0]  din_sh;
   logic                     pick_found;
   drive_idx_t               pick_idx;

`ifdef C1541_SDARB_TIMEOUT_EN
   logic [23:0]              cnt_q, cnt_d;
   logic                     timeout_err_q, timeout_err_d;
`else
   logic                     unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   assign pending = bus.req_rd | bus.req_wr;
   assign wr_sh   = bus.req_wr >> pick_idx;
   assign lba_sh  = bus.req_lba >> {pick_idx, 5'b00000};
   assign din_sh  = bus.req_buff_din >> {grant_q, 3'b000};

   c1541_rr_pick #(
      .NUM_REQ (NUM_DRIVES)
   ) u_pick (
      .pending_i (pending),
      .rr_ptr_i  (rr_ptr_q),
      .found_o   (pick_found),
      .index_o   (pick_idx)
   );

   // Next-state: grant in IDLE, wait for ack in ISSUE, wait for ack fall in XFER.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      lba_d    = lba_q;
      op_d     = op_q;
`ifdef C1541_SDARB_TIMEOUT_EN
      cnt_d         = cnt_q;
      timeout_err_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            // sd_ack here is a stray or late ack and is deliberately ignored.
            if (pick_found) begin
               grant_d = pick_idx;
               lba_d   = lba_sh[31:0];
               op_d    = wr_sh[0] ? OP_WR : OP_RD;
               state_d = ISSUE;
`ifdef C1541_SDARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ISSUE: begin
            if (bus.sd_ack) state_d = XFER;
`ifdef C1541_SDARB_TIMEOUT_EN
            else if (cnt_q == TIMEOUT - 24'd1) begin
               state_d       = IDLE;
               rr_ptr_d      = rr_next(grant_q, NUM_DRIVES);
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
`endif
         end
         XFER: begin
            if (!bus.sd_ack) begin
               state_d  = IDLE;
               rr_ptr_d = rr_next(grant_q, NUM_DRIVES);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         lba_q    <= '0;
         op_q     <= OP_RD;
`ifdef C1541_SDARB_TIMEOUT_EN
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         lba_q    <= lba_d;
         op_q     <= op_d;
`ifdef C1541_SDARB_TIMEOUT_EN
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   // Outputs: HPS requests from state, ack/strobe routed to the granted requester in XFER.
   always_comb begin
      bus.sd_rd       = (state_q == ISSUE) && (op_q == OP_RD);
      bus.sd_wr       = (state_q == ISSUE) && (op_q == OP_WR);
      bus.sd_lba      = lba_q;
      bus.grant       = grant_q;
      bus.busy        = (state_q != IDLE);
      bus.sd_buff_din = (state_q != IDLE) ? din_sh[7:0] : 8'h00;
      bus.req_ack     = '0;
      bus.req_buff_wr = '0;
      for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
         if ((state_q == XFER) && (grant_q == drive_idx_t'(i))) begin
            bus.req_ack[i]     = bus.sd_ack;
            bus.req_buff_wr[i] = bus.sd_buff_wr;
         end
      end
   end

`ifdef C1541_SDARB_TIMEOUT_EN
   assign bus.timeout_err = timeout_err_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Self-checking bench for c1541_sd_arbiter (two drives, TIMEOUT=16).
module tb_c1541_sd_arbiter;
   import c1541_pkg::*;

   localparam int unsigned ND = 2;
   localparam logic [23:0] TO = 24'd16;
   localparam logic [31:0] L0 = 32'h0000_0245;
   localparam logic [31:0] L1 = 32'h1000_0001;

   logic clk = 1'b0;
   logic reset;

   c1541_sd_arbiter_if #(.NUM_DRIVES(ND)) bus ();

   c1541_sd_arbiter #(
      .NUM_DRIVES (ND),
      .TIMEOUT    (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  rd;
      logic [1:0]  wr;
      logic [1:0]  g;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_lba;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_rd       = '0;
      bus.req_wr       = '0;
      bus.req_lba      = {L1, L0};
      bus.req_buff_din = '0;
      bus.sd_ack       = 1'b0;
      bus.sd_buff_wr   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      reset = 1'b0;
   endtask

   // Random-phase model state: requester levels, LBAs, round-robin pointer.
   logic [ND-1:0] m_rd, m_wr, onehot;
   logic [31:0]   m_lba[ND];
   int            m_ptr, g, idx, cnt1, cnt0, dinerr, early;
   logic          e_wr;
   logic [31:0]   e_lba;
   logic [15:0]   din;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      chk("rst_sd_rd", bus.sd_rd, 0);
      chk("rst_sd_wr", bus.sd_wr, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_sd_lba", bus.sd_lba, 0);
      chk("rst_req_ack", bus.req_ack, 0);
      chk("rst_buff_wr", bus.req_buff_wr, 0);
      chk("rst_buff_din", bus.sd_buff_din, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
      reset = 1'b0;

      // Table: one transfer per entry; pointer carries between entries.
      vt[0] = '{rd: 2'b01, wr: 2'b00, g: 2'd0, e_rd: 1, e_wr: 0, e_lba: L0};
      vt[1] = '{rd: 2'b01, wr: 2'b10, g: 2'd1, e_rd: 0, e_wr: 1, e_lba: L1};
      vt[2] = '{rd: 2'b01, wr: 2'b01, g: 2'd0, e_rd: 0, e_wr: 1, e_lba: L0};
      vt[3] = '{rd: 2'b11, wr: 2'b00, g: 2'd1, e_rd: 1, e_wr: 0, e_lba: L1};
      vt[4] = '{rd: 2'b10, wr: 2'b00, g: 2'd1, e_rd: 1, e_wr: 0, e_lba: L1};
      vt[5] = '{rd: 2'b00, wr: 2'b10, g: 2'd1, e_rd: 0, e_wr: 1, e_lba: L1};
      vt[6] = '{rd: 2'b01, wr: 2'b00, g: 2'd0, e_rd: 1, e_wr: 0, e_lba: L0};
      vt[7] = '{rd: 2'b00, wr: 2'b01, g: 2'd0, e_rd: 0, e_wr: 1, e_lba: L0};
      for (int i = 0; i < 8; i++) begin
         bus.req_rd = vt[i].rd;
         bus.req_wr = vt[i].wr;
         tick();
         chk("tbl_grant", bus.grant, vt[i].g);
         chk("tbl_sd_rd", bus.sd_rd, vt[i].e_rd);
         chk("tbl_sd_wr", bus.sd_wr, vt[i].e_wr);
         chk("tbl_sd_lba", bus.sd_lba, vt[i].e_lba);
         bus.sd_ack = 1'b1;
         tick();
         onehot = '0;
         onehot[vt[i].g] = 1'b1;
         chk("tbl_req_ack", bus.req_ack, onehot);
         bus.req_rd = '0;
         bus.req_wr = '0;
         bus.sd_ack = 1'b0;
         tick();
         chk("tbl_done_busy", bus.busy, 0);
      end

      // Single read, with a stray ack while idle first.
      do_reset();
      bus.sd_ack = 1'b1;
      tick();
      chk("idle_ack_fwd", bus.req_ack, 0);
      chk("idle_ack_busy", bus.busy, 0);
      chk("idle_ack_rd", bus.sd_rd, 0);
      bus.sd_ack = 1'b0;
      bus.req_rd = 2'b01;
      tick();
      chk("single_sd_rd", bus.sd_rd, 1);
      chk("single_lba", bus.sd_lba, 32'h245);
      chk("single_grant", bus.grant, 0);
      chk("single_busy", bus.busy, 1);
      bus.sd_ack = 1'b1;
      tick();
      chk("single_rd_drop", bus.sd_rd, 0);
      chk("single_req_ack", bus.req_ack, 2'b01);
      bus.req_rd = '0;
      bus.sd_ack = 1'b0;
      tick();
      chk("single_idle", bus.busy, 0);

      // Collision after reset, then buffer isolation on drive 1.
      do_reset();
      bus.req_rd = 2'b01;
      bus.req_wr = 2'b10;
      tick();
      chk("coll_first_grant", bus.grant, 0);
      chk("coll_first_rd", bus.sd_rd, 1);
      bus.sd_ack = 1'b1;
      tick();
      bus.req_rd = '0;
      bus.sd_ack = 1'b0;
      tick();
      chk("coll_dead_busy", bus.busy, 0);
      chk("coll_dead_wr", bus.sd_wr, 0);
      tick();
      chk("coll_second_grant", bus.grant, 1);
      chk("coll_second_wr", bus.sd_wr, 1);
      chk("coll_second_rd", bus.sd_rd, 0);
      chk("coll_second_lba", bus.sd_lba, L1);
      bus.sd_ack = 1'b1;
      tick();
      bus.req_wr = '0;
      cnt1 = 0;
      cnt0 = 0;
      dinerr = 0;
      for (int i = 0; i < 1024; i++) begin
         bus.sd_buff_wr = (i % 2 == 0);
         din = 16'($urandom);
         bus.req_buff_din = din;
         settle();
         if (bus.req_buff_wr[1]) cnt1++;
         if (bus.req_buff_wr[0]) cnt0++;
         if (bus.sd_buff_din !== din[15:8]) dinerr++;
         tick();
      end
      chk("iso_pulses_d1", cnt1, 512);
      chk("iso_pulses_d0", cnt0, 0);
      chk("iso_din_errors", dinerr, 0);
      bus.sd_buff_wr = 1'b0;
      bus.sd_ack = 1'b0;
      tick();
      chk("iso_done_busy", bus.busy, 0);
      chk("iso_idle_din", bus.sd_buff_din, 0);

      // Reset during XFER, then re-grant one cycle after reset drops.
      do_reset();
      bus.req_rd = 2'b10;
      tick();
      chk("rx_grant", bus.grant, 1);
      bus.sd_ack = 1'b1;
      tick();
      chk("rx_req_ack", bus.req_ack, 2'b10);
      reset = 1'b1;
      bus.sd_buff_wr = 1'b1;
      tick();
      chk("rx_sd_rd", bus.sd_rd, 0);
      chk("rx_sd_wr", bus.sd_wr, 0);
      chk("rx_busy", bus.busy, 0);
      chk("rx_req_ack0", bus.req_ack, 0);
      chk("rx_buff_wr", bus.req_buff_wr, 0);
      chk("rx_lba", bus.sd_lba, 0);
      chk("rx_grant0", bus.grant, 0);
      reset = 1'b0;
      bus.sd_ack = 1'b0;
      bus.sd_buff_wr = 1'b0;
      bus.req_rd = 2'b11;
      tick();
      chk("rx_regrant_rd", bus.sd_rd, 1);
      chk("rx_regrant_ptr", bus.grant, 0);
      bus.sd_ack = 1'b1;
      tick();
      bus.req_rd = '0;
      bus.sd_ack = 1'b0;
      tick();

`ifdef C1541_SDARB_TIMEOUT_EN
      do_reset();
      bus.req_rd = 2'b01;
      bus.req_wr = 2'b10;
      tick();
      chk("to_issue", bus.sd_rd, 1);
      early = 0;
      for (int i = 1; i < 16; i++) begin
         tick();
         if (bus.sd_rd !== 1'b1 || bus.timeout_err !== 1'b0) early++;
      end
      chk("to_early_abort", early, 0);
      tick();
      chk("to_rd_drop", bus.sd_rd, 0);
      chk("to_err_pulse", bus.timeout_err, 1);
      chk("to_busy", bus.busy, 0);
      tick();
      chk("to_err_clear", bus.timeout_err, 0);
      chk("to_next_grant", bus.grant, 1);
      chk("to_next_wr", bus.sd_wr, 1);
      bus.sd_ack = 1'b1;
      tick();
      clear_inputs();
      tick();
`endif

      // Randomized transfers against a round-robin model.
      do_reset();
      m_rd = '0;
      m_wr = '0;
      m_ptr = 0;
      for (int d = 0; d < ND; d++) m_lba[d] = 32'($urandom);
      for (int t = 0; t < 60; t++) begin
         for (int d = 0; d < ND; d++) begin
            if (!m_rd[d] && !m_wr[d] && $urandom_range(0, 1) == 1) begin
               case ($urandom_range(0, 2))
                  0: m_rd[d] = 1'b1;
                  1: m_wr[d] = 1'b1;
                  default: begin
                     m_rd[d] = 1'b1;
                     m_wr[d] = 1'b1;
                  end
               endcase
               m_lba[d] = 32'($urandom);
            end
         end
         if ((m_rd | m_wr) == '0) m_rd[$urandom_range(0, ND - 1)] = 1'b1;
         bus.req_rd = m_rd;
         bus.req_wr = m_wr;
         for (int d = 0; d < ND; d++) bus.req_lba[32*d +: 32] = m_lba[d];
         g = -1;
         for (int k = 0; k < ND; k++) begin
            idx = (m_ptr + k) % ND;
            if (g < 0 && (m_rd[idx] || m_wr[idx])) g = idx;
         end
         e_wr  = m_wr[g];
         e_lba = m_lba[g];
         tick();
         chk("rnd_grant", bus.grant, g);
         chk("rnd_op", {bus.sd_rd, bus.sd_wr}, {!e_wr, e_wr});
         chk("rnd_lba", bus.sd_lba, e_lba);
         m_lba[g] = 32'($urandom);
         bus.req_lba[32*g +: 32] = m_lba[g];
         repeat ($urandom_range(0, 3)) begin
            tick();
            chk("rnd_issue_hold", {bus.sd_rd, bus.sd_wr}, {!e_wr, e_wr});
         end
         bus.sd_ack = 1'b1;
         tick();
         chk("rnd_req_drop", {bus.sd_rd, bus.sd_wr}, 0);
         m_rd[g] = 1'b0;
         m_wr[g] = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, ND - 1);
            m_rd[idx] = 1'b0;
            m_wr[idx] = 1'b0;
         end
         bus.req_rd = m_rd;
         bus.req_wr = m_wr;
         onehot = '0;
         onehot[g] = 1'b1;
         repeat ($urandom_range(1, 6)) begin
            bus.sd_buff_wr = 1'($urandom);
            din = 16'($urandom);
            bus.req_buff_din = din;
            settle();
            chk("rnd_req_ack", bus.req_ack, onehot);
            chk("rnd_buff_wr", bus.req_buff_wr, bus.sd_buff_wr ? onehot : 2'b00);
            chk("rnd_buff_din", bus.sd_buff_din, (g == 1) ? din[15:8] : din[7:0]);
            tick();
         end
         chk("rnd_lba_stable", bus.sd_lba, e_lba);
         bus.sd_ack = 1'b0;
         bus.sd_buff_wr = 1'b0;
         tick();
         chk("rnd_done_busy", bus.busy, 0);
         chk("rnd_done_ack", bus.req_ack, 0);
         m_ptr = (g + 1) % ND;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/c1541_sd_arbiter.md
Name: c1541_sd_arbiter

Overview:
- Shares one SD block-device channel (sd_lba/sd_rd/sd_wr/sd_ack plus sector-buffer strobes) between NUM_DRIVES track-buffer modules, e.g. drives 8 and 9.
- Grants one requester at a time, round-robin, and holds the grant for one full LBA transfer (request, ack rise, ack fall).
- Routes buffer-write strobes and read-back data to and from the granted requester only.
- Sits between the per-drive track modules and the HPS sd interface, all on clk.

Parameters:
- NUM_DRIVES, 2: number of requesters, 1..4.
- TIMEOUT, 24'd8000000: clk cycles to wait for sd_ack rise before aborting. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_lba  in  32*NUM_DRIVES  per-requester LBA; requester i occupies bits [32i+31:32i]
- req_rd  in  NUM_DRIVES  level read request, held until its ack rises
- req_wr  in  NUM_DRIVES  level write request, held until its ack rises
- req_ack  out  NUM_DRIVES  sd_ack forwarded to the granted requester only
- req_buff_din  in  8*NUM_DRIVES  per-requester sector read-back byte for SD writes
- req_buff_wr  out  NUM_DRIVES  sd_buff_wr gated to the granted requester
- sd_lba  out  32  latched LBA of the current transfer
- sd_rd  out  1  read request to HPS
- sd_wr  out  1  write request to HPS
- sd_ack  in  1  HPS transfer acknowledge
- sd_buff_wr  in  1  HPS sector-byte write strobe
- sd_buff_din  out  8  req_buff_din of the granted requester; 0 when idle
- grant  out  2  index of the current or last granted requester
- busy  out  1  high from grant until ack-fall completion
- timeout_err  out  1  one-cycle pulse on abort

Behaviour:
Reset (synchronous):
- state=IDLE; rr_ptr=0; grant=0.
- sd_rd, sd_wr, busy, timeout_err, req_ack, req_buff_wr all 0; sd_lba=0.
- Reset mid-transfer aborts immediately. Requesters see their ack drop and must re-request.

IDLE:
- pending[i] = req_rd[i] | req_wr[i].
- Pick the first pending index scanning rr_ptr, rr_ptr+1, ... modulo NUM_DRIVES.
- If one is found, on the same edge: latch grant and sd_lba=req_lba[grant]; op=WR if req_wr[grant], else RD (wr wins when both are set); busy=1; go to ISSUE.
- sd_rd/sd_wr become visible 1 cycle after the request is seen.
- sd_ack while IDLE is ignored and not forwarded.

ISSUE:
- Hold sd_rd or sd_wr per op.
- On sd_ack=1: drop sd_rd/sd_wr; go to XFER.

XFER:
- req_ack[grant]=sd_ack (combinational).
- req_buff_wr[grant]=sd_buff_wr (combinational).
- sd_buff_din=req_buff_din[grant].
- On sd_ack=0: busy=0; rr_ptr=grant+1 (wrapping to 0 past NUM_DRIVES-1); go to IDLE.
- The next grant can occur on the cycle after return to IDLE (one dead cycle minimum).

Request handling rules:
- A requester's LBA or request change after grant has no effect on the current transfer.
- A request dropped before grant is never served.
- Non-granted requesters always see req_ack=0 and req_buff_wr=0.
- With NUM_DRIVES=1 the block degenerates to a registered pass-through with the same state sequence.

Optional Feature:
- Macro C1541_SDARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE.
  - On reaching TIMEOUT: drop sd_rd/sd_wr, pulse timeout_err for 1 cycle, busy=0, advance rr_ptr past grant, return to IDLE.
  - A late sd_ack that arrives in IDLE is ignored.
- Undefined: no counter; ISSUE waits indefinitely; timeout_err is tied to 0.

Decomposition:
- Package c1541_pkg:
  - typedef enum arb_state_t {IDLE, ISSUE, XFER}
  - typedef enum sd_op_t {OP_RD, OP_WR}
  - localparam MAX_DRIVES=4
- Sub-module c1541_rr_pick: combinational round-robin priority picker. Inputs pending and rr_ptr; outputs found and index. Reusable for other shared HPS channels.

Test Plan:
- Single read: req_rd[0]=1, req_lba[0]=0x00000245 → next cycle sd_rd=1, sd_lba=0x245, grant=0. sd_ack rises → sd_rd=0, req_ack[0]=1. sd_ack falls → busy=0 and state IDLE.
- Collision: req_rd[0] and req_wr[1] asserted in the same cycle after reset → drive 0 is served first, then drive 1 with sd_wr=1, one dead cycle between. A repeat collision serves drive 1 first.
- Buffer isolation: granted=1 with sd_buff_wr pulsed 512 times → req_buff_wr[1] pulses 512 times and req_buff_wr[0] stays 0. sd_buff_din equals req_buff_din[1] throughout.
- rd and wr both high on drive 0 → sd_wr=1, sd_rd=0.
- Reset asserted during XFER → all outputs 0 the next cycle, rr_ptr=0. A held request is re-granted 1 cycle after reset drops.
- With C1541_SDARB_TIMEOUT_EN and TIMEOUT=16, no sd_ack → sd_rd drops and timeout_err=1 exactly 16 cycles after ISSUE entry. The next pending requester is granted after that.
